// File: rtl/fifo_write_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_write_ctrl
//
// Write-side front end for an asynchronous FIFO. Upstream words enter through
// a 2-entry in-order skid buffer. The buffer drains into the FIFO whenever it
// holds a word and the FIFO is not full.
//
// Optional feature macro: FIFO_WR_STATS_EN. When it is defined, the block gains
// the parameter STAT_SIZE and two statistics outputs:
//   wr_count    - FIFO writes, wraps modulo 2^STAT_SIZE
//   stall_count - cycles with buffered data blocked by full, saturates
//
// Ports:
//   wclk        in   write-domain clock, rising edge
//   w_rst       in   synchronous active-high reset, wins over flush
//   flush       in   synchronous discard of buffered words
//   s_valid     in   upstream word valid
//   s_data      in   upstream word [DATA_SIZE]
//   s_ready     out  registered; a word is accepted when s_valid & s_ready
//   full        in   registered FIFO-full flag
//   w_en        out  FIFO write enable, (buf_cnt != 0) & ~full
//   w_data      out  oldest buffered word, valid while w_en is high
//   buf_cnt     out  skid-buffer occupancy 0..2; this is the FSM state
//   wr_count    out  [STAT_SIZE] (FIFO_WR_STATS_EN only)
//   stall_count out  [STAT_SIZE] (FIFO_WR_STATS_EN only)
//
// Handshake: a word moves on the upstream side when s_valid and s_ready are
// both high at a wclk edge. s_ready never depends on s_valid in the same cycle.
// w_en is a pure write strobe. The FIFO cannot refuse a write while full is low.
// -----------------------------------------------------------------------------
module fifo_write_ctrl #(
  parameter int DATA_SIZE = 8
`ifdef FIFO_WR_STATS_EN
  , parameter int STAT_SIZE = 16
`endif
) (
  input  logic                 wclk,
  input  logic                 w_rst,
  input  logic                 flush,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 s_ready,
  input  logic                 full,
  output logic                 w_en,
  output logic [DATA_SIZE-1:0] w_data,
  output logic [1:0]           buf_cnt
`ifdef FIFO_WR_STATS_EN
  , output logic [STAT_SIZE-1:0] wr_count
  , output logic [STAT_SIZE-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                 occ_q, occ_d;
  logic                 s_ready_q;
  // mem0 always holds the oldest word and mem1 the younger one.
  logic [DATA_SIZE-1:0] mem0_q, mem0_d;
  logic [DATA_SIZE-1:0] mem1_q, mem1_d;
  logic                 accept;
  logic                 drain;

  assign accept  = s_valid & s_ready_q;
  assign drain   = (occ_q != EMPTY) & ~full;
  assign w_en    = drain;
  assign w_data  = mem0_q;
  assign s_ready = s_ready_q;
  assign buf_cnt = occ_q;

  always_comb begin
    occ_d  = occ_q;
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    if (flush) begin
      // The write strobe this cycle still goes out. Only the buffer is cleared.
      occ_d = EMPTY;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (accept) begin
            mem0_d = s_data;
            occ_d  = ONE;
          end
        end
        ONE: begin
          case ({accept, drain})
            // The head leaves on w_data now, and the new word becomes the head.
            2'b11: mem0_d = s_data;
            2'b10: begin
              mem1_d = s_data;
              occ_d  = TWO;
            end
            2'b01: occ_d = EMPTY;
            default: occ_d = occ_q;
          endcase
        end
        TWO: begin
          // s_ready is low here, so the only possible move is a drain.
          if (drain) begin
            mem0_d = mem1_q;
            occ_d  = ONE;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      occ_q     <= EMPTY;
      s_ready_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      // s_ready looks ahead one cycle, so a word is never offered into a full buffer.
      s_ready_q <= (occ_d != TWO);
    end
    // The storage needs no reset. It is only read while occupancy is nonzero.
    mem0_q <= mem0_d;
    mem1_q <= mem1_d;
  end

`ifdef FIFO_WR_STATS_EN
  logic [STAT_SIZE-1:0] wr_count_q;
  logic [STAT_SIZE-1:0] stall_count_q;

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (w_en) begin
        wr_count_q <= wr_count_q + STAT_SIZE'(1);
      end
      if ((occ_q != EMPTY) && full && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + STAT_SIZE'(1);
      end
    end
  end

  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_ctrl
//
// Bench for fifo_write_ctrl. Inputs change 1 ns after each rising edge.
// Scenario tasks check outputs right after driving, before the next edge.
// A negedge monitor holds an in-order model of the skid buffer in exp_q and
// compares buf_cnt, s_ready, w_en and w_data against that model every cycle.
// -----------------------------------------------------------------------------
module tb_fifo_write_ctrl;

  logic       clk = 1'b0;
  logic       w_rst;
  logic       flush;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       full;
  logic       w_en;
  logic [7:0] w_data;
  logic [1:0] buf_cnt;
`ifdef FIFO_WR_STATS_EN
  logic [3:0] wr_count;
  logic [3:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

`ifdef FIFO_WR_STATS_EN
  fifo_write_ctrl #(.DATA_SIZE(8), .STAT_SIZE(4)) dut (
`else
  fifo_write_ctrl #(.DATA_SIZE(8)) dut (
`endif
    .wclk    (clk),
    .w_rst   (w_rst),
    .flush   (flush),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .full    (full),
    .w_en    (w_en),
    .w_data  (w_data),
    .buf_cnt (buf_cnt)
`ifdef FIFO_WR_STATS_EN
    , .wr_count    (wr_count)
    , .stall_count (stall_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       exp_ready;
  logic       exp_wen;
  logic [1:0] exp_cnt;
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_cnt = 2'(exp_q.size());
      exp_wen = (exp_q.size() != 0) && !full;
      checks++;
      if (buf_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL mon_buf_cnt t=%0t got=%0d exp=%0d", $time, buf_cnt, exp_cnt);
      end
      checks++;
      if (s_ready !== exp_ready) begin
        failures++;
        $display("FAIL mon_s_ready t=%0t got=%b exp=%b", $time, s_ready, exp_ready);
      end
      checks++;
      if (w_en !== exp_wen) begin
        failures++;
        $display("FAIL mon_w_en t=%0t got=%b exp=%b", $time, w_en, exp_wen);
      end
      if (exp_wen) begin
        checks++;
        if (w_data !== exp_q[0]) begin
          failures++;
          $display("FAIL mon_w_data t=%0t got=%h exp=%h", $time, w_data, exp_q[0]);
        end
      end
      // Model update for the coming rising edge.
      if (w_rst) begin
        exp_q.delete();
        exp_ready = 1'b0;
      end else if (flush) begin
        exp_q.delete();
        exp_ready = 1'b1;
      end else begin
        if (exp_wen) void'(exp_q.pop_front());
        if (s_valid && exp_ready) exp_q.push_back(s_data);
        exp_ready = (exp_q.size() != 2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    // Kept local to the scenario call sites below; each test issues its own compare.
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic test_reset();
    w_rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; full = 1'b0;
    tick();
    exp_q.delete();
    exp_ready = 1'b0;
    mon_en = 1'b1;
    tick();
    checks++;
    if (buf_cnt !== 2'd0) begin failures++; $display("FAIL rst_buf_cnt got=%0d exp=0", buf_cnt); end
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    checks++;
    if (w_en !== 1'b0) begin failures++; $display("FAIL rst_w_en got=%b exp=0", w_en); end
    w_rst = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise got=%b exp=1", s_ready); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      tick();
      checks++;
      if (buf_cnt !== 2'd1) begin failures++; $display("FAIL stream_cnt got=%0d exp=1", buf_cnt); end
      checks++;
      if (w_en !== 1'b1 || w_data !== 8'(i)) begin
        failures++;
        $display("FAIL stream_data got=%b/%h exp=1/%h", w_en, w_data, 8'(i));
      end
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (buf_cnt !== 2'd0) begin failures++; $display("FAIL stream_empty got=%0d exp=0", buf_cnt); end
  endtask

  task automatic test_full_backpressure();
    full = 1'b1; s_valid = 1'b1; s_data = 8'hA0;
    tick();
    checks++;
    if (w_en !== 1'b0) begin failures++; $display("FAIL bp_w_en_full got=%b exp=0", w_en); end
    s_data = 8'hA1;
    tick();
    checks++;
    if (buf_cnt !== 2'd2 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_fill got=%0d/%b exp=2/0", buf_cnt, s_ready);
    end
    s_data = 8'hA2;
    tick();
    checks++;
    if (buf_cnt !== 2'd2 || w_data !== 8'hA0) begin
      failures++;
      $display("FAIL bp_hold got=%0d/%h exp=2/a0", buf_cnt, w_data);
    end
    full = 1'b0;
    #1;
    checks++;
    if (w_en !== 1'b1) begin failures++; $display("FAIL bp_resume_same_cycle got=%b exp=1", w_en); end
    tick();
    chk("bp_second", w_data, 8'hA1);
    tick();
    chk("bp_third", w_data, 8'hA2);
    s_valid = 1'b0;
    tick();
    chk("bp_drained", {6'b0, buf_cnt}, 8'h00);
  endtask

  task automatic test_simul_accept_drain();
    s_valid = 1'b1; s_data = 8'h10;
    tick();
    s_data = 8'h11;
    chk("sim_head_old", w_data, 8'h10);
    tick();
    chk("sim_head_new", w_data, 8'h11);
    chk("sim_cnt", {6'b0, buf_cnt}, 8'h01);
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    full = 1'b1; s_valid = 1'b1; s_data = 8'h20;
    tick();
    s_data = 8'h21;
    tick();
    s_data = 8'h55; flush = 1'b1;
    tick();
    flush = 1'b0; s_valid = 1'b0;
    checks++;
    if (buf_cnt !== 2'd0 || w_en !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_state got=%0d/%b/%b exp=0/0/1", buf_cnt, w_en, s_ready);
    end
    full = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    full = 1'b1; s_valid = 1'b1; s_data = 8'h30;
    tick();
    s_data = 8'h31;
    tick();
    s_valid = 1'b0; w_rst = 1'b1;
    tick();
    full = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || buf_cnt !== 2'd0 || w_en !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state got=%b/%0d/%b exp=0/0/0", s_ready, buf_cnt, w_en);
    end
    tick();
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_hold got=%b exp=0", s_ready); end
`ifdef FIFO_WR_STATS_EN
    checks++;
    if (wr_count !== 4'd0 || stall_count !== 4'd0) begin
      failures++;
      $display("FAIL midrst_stats got=%0d/%0d exp=0/0", wr_count, stall_count);
    end
`endif
    w_rst = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1 || buf_cnt !== 2'd0) begin
      failures++;
      $display("FAIL midrst_after got=%b/%0d exp=1/0", s_ready, buf_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom_range(0, 255));
      full    = ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 31) == 0);
      tick();
    end
    s_valid = 1'b0; full = 1'b0; flush = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (buf_cnt !== 2'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain got=%0d exp=0 model=%0d", buf_cnt, exp_q.size());
    end
  endtask

`ifdef FIFO_WR_STATS_EN
  task automatic test_stats();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    tick();
    full = 1'b1; s_valid = 1'b1; s_data = 8'h40;
    tick();
    s_valid = 1'b0;
    repeat (20) tick();
    chk("stats_stall_sat", {4'b0, stall_count}, 8'd15);
    chk("stats_no_write", {4'b0, wr_count}, 8'd0);
    full = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = 8'(8'h41 + i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    chk("stats_wr_wrap", {4'b0, wr_count}, 8'd1);
    chk("stats_stall_kept", {4'b0, stall_count}, 8'd15);
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stream();
    test_full_backpressure();
    test_simul_accept_drain();
    test_flush();
    test_mid_reset();
    test_back_to_back();
`ifdef FIFO_WR_STATS_EN
    test_stats();
`endif
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 Parameter DATA_SIZE, default 8, width of stream and FIFO write data.
REQ-002 Parameter STAT_SIZE, default 16, width of statistics counters (Configuration only).
REQ-003 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 w_rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all buffered words.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_data  input  DATA_SIZE  upstream word.
REQ-008 s_ready  output  1  registered; block accepts word this cycle when high.
REQ-009 full  input  1  registered FIFO-full flag from write pointer logic.
REQ-010 w_en  output  1  FIFO write enable.
REQ-011 w_data  output  DATA_SIZE  FIFO write data, valid when w_en high.
REQ-012 buf_cnt  output  2  current skid-buffer occupancy, 0..2.

Function
REQ-013 The block shall hold a 2-entry in-order skid buffer with occupancy states EMPTY(0), ONE(1) and TWO(2).
REQ-014 The block shall define accept = s_valid & s_ready and drain = w_en.
REQ-015 w_en shall be combinational: (buf_cnt != 0) & ~full, with no dependency on s_valid.
REQ-016 w_data shall equal the oldest buffered word, combinational from registered storage.
REQ-017 Next occupancy shall be buf_cnt + accept - drain; EMPTY->ONE on accept only, ONE->TWO on accept only, TWO->ONE on drain only, ONE->EMPTY on drain only, unchanged on both or neither.
REQ-018 s_ready shall be registered as (next occupancy != 2), so no word is accepted while occupancy is 2.
REQ-019 Simultaneous accept and drain at ONE shall write the new word and output the old one in the same cycle, keeping occupancy ONE with the new word as head next cycle.
REQ-020 Words shall leave on w_data in exactly their s_data acceptance order; none duplicated or dropped (except by flush or reset).
REQ-021 Minimum latency shall be one cycle: word accepted at edge N appears with w_en at cycle N+1 when full is low.
REQ-022 While full is high, w_en shall be 0 and buffer contents shall hold.
REQ-023 When full deasserts, draining shall resume the same cycle.
REQ-024 flush high shall take priority over accept and drain: occupancy goes to 0 next cycle, s_ready goes to 1 next cycle, and any word offered that cycle is discarded.
REQ-025 w_en asserted during a flush cycle still counts as a FIFO write; the flush affects only the buffer state for the next cycle.

Reset
REQ-026 While w_rst is high at a wclk edge: buf_cnt=0, s_ready=0, and storage is don't-care with w_en=0 because buf_cnt is 0.
REQ-027 s_ready shall rise on the first edge after w_rst deasserts.
REQ-028 Reset asserted mid-operation shall discard buffered words identically to flush, and s_ready shall be 0 throughout reset.
REQ-029 Reset shall take priority over flush.

Configuration
REQ-030 Macro FIFO_WR_STATS_EN defined: the block shall add outputs wr_count (STAT_SIZE) and stall_count (STAT_SIZE), both reset to 0.
REQ-031 With FIFO_WR_STATS_EN defined, wr_count shall increment by one per cycle with w_en high and wrap modulo 2^STAT_SIZE.
REQ-032 With FIFO_WR_STATS_EN defined, stall_count shall increment per cycle with buf_cnt != 0 and full high, and saturate at all-ones.
REQ-033 With FIFO_WR_STATS_EN defined, flush shall not clear either counter.
REQ-034 Macro FIFO_WR_STATS_EN undefined: wr_count, stall_count and their logic shall be absent, and all other behaviour shall be identical.

Verification
REQ-035 Reset, then s_valid=1 continuously with data 0x01,0x02,0x03, full=0 -> s_ready=1 from first post-reset edge; w_data 0x01,0x02,0x03 on consecutive cycles one cycle after each acceptance; buf_cnt stays 1.
REQ-036 full=1, offer 0xA0,0xA1,0xA2 -> 0xA0 and 0xA1 accepted, s_ready drops with buf_cnt=2, 0xA2 held upstream; full=0 -> w_data 0xA0,0xA1,0xA2 in order; no loss.
REQ-037 buf_cnt=1 holding 0x10, accept 0x11 while draining -> w_data=0x10 that cycle, 0x11 next; buf_cnt remains 1.
REQ-038 buf_cnt=2 and s_valid=1 with 0x55, pulse flush -> next cycle buf_cnt=0, w_en=0, s_ready=1; 0x55 never appears on w_data.
REQ-039 w_rst pulsed with buf_cnt=2 -> s_ready=0 during reset; afterwards buf_cnt=0, w_en=0; with FIFO_WR_STATS_EN, wr_count=stall_count=0.
REQ-040 With FIFO_WR_STATS_EN and STAT_SIZE=4, hold full=1 for 20 cycles with buf_cnt=1 -> stall_count=15; then 17 writes -> wr_count=1.
